// File: rtl/imm_pkg.sv
// imm_pkg: opcodes, immediate kinds and the decoded-entry record shared by the decode stage.
package imm_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_C} imm_type_e;

    // Datapath fields are held at the widest legal XLEN; the stage keeps the low XLEN bits.
    typedef struct packed {
        logic [63:0] imm;
        imm_type_e   imm_type;
        logic [63:0] target;
        logic        illegal;
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate/target decode of one instruction.
// Compressed immediates are decoded only when RVC_IMM_EN is defined.
module imm_extract import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output entry_t          e
);
    logic [63:0] imm;
    imm_type_e   t;
    logic        ill;
    logic        tgt;

    always_comb begin
        imm = '0;
        t   = IMM_NONE;
        ill = 1'b0;
        tgt = 1'b0;
        if (inst[1:0] != 2'b11) begin
`ifdef RVC_IMM_EN
            t = IMM_C;
            case ({inst[15:13], inst[1:0]})
                5'b000_01, 5'b010_01: imm = {{58{inst[12]}}, inst[12], inst[6:2]};
                5'b011_01: imm = {{46{inst[12]}}, inst[12], inst[6:2], 12'b0};
                5'b010_00, 5'b110_00: imm = {57'b0, inst[5], inst[12:10], inst[6], 2'b0};
                5'b001_01, 5'b101_01: begin
                    imm = {{52{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                           inst[2], inst[11], inst[5:3], 1'b0};
                    tgt = 1'b1;
                end
                5'b110_01, 5'b111_01: begin
                    imm = {{55{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
                    tgt = 1'b1;
                end
                default: begin
                    t   = IMM_NONE;
                    ill = 1'b1;
                end
            endcase
`else
            ill = 1'b1;
`endif
        end else begin
            case (inst[6:0])
                OP_LOAD, OP_OPIMM, OP_JALR: begin
                    t   = IMM_I;
                    imm = {{52{inst[31]}}, inst[31:20]};
                end
                OP_STORE: begin
                    t   = IMM_S;
                    imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
                end
                OP_BRANCH: begin
                    t   = IMM_B;
                    imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                    tgt = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    t   = IMM_U;
                    imm = {{32{inst[31]}}, inst[31:12], 12'b0};
                    tgt = inst[6:0] == OP_AUIPC;
                end
                OP_JAL: begin
                    t   = IMM_J;
                    imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                    tgt = 1'b1;
                end
                OP_OP, OP_SYSTEM, OP_FENCE: ;
                default: ill = 1'b1;
            endcase
        end
    end

    assign e = '{imm: imm, imm_type: t, target: tgt ? 64'(pc) + imm : '0,
                 illegal: ill, inst: inst, pc: 64'(pc)};
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decode with a 2-entry skid buffer on valid/ready.
// Optional RVC_IMM_EN enables compressed-immediate decode.
module imm_decode_stage import imm_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] dec_count
);
    entry_t in_e, out_q, skid_q;
    logic   out_v, skid_v, accept, drain;

    imm_extract #(.XLEN(XLEN)) u_extract (.inst(in_inst), .pc(in_pc), .e(in_e));

    assign accept = in_valid & ~skid_v;
    assign drain  = ~out_v | out_ready;

    // The skid only fills while the output is stalled, so it never coexists with an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_v     <= 1'b0;
            skid_v    <= 1'b0;
            dec_count <= '0;
        end else begin
            if (out_v && out_ready) dec_count <= dec_count + CNT_W'(1);
            if (drain) begin
                if (skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end else begin
                    out_v <= accept;
                    if (accept) out_q <= in_e;
                end
            end else if (accept) begin
                skid_q <= in_e;
                skid_v <= 1'b1;
            end
        end
    end

    assign in_ready    = ~skid_v;
    assign out_valid   = out_v;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_type    = out_q.imm_type;
    assign out_target  = out_q.target[XLEN-1:0];
    assign out_illegal = out_q.illegal;
    assign out_inst    = out_q.inst;
    assign out_pc      = out_q.pc[XLEN-1:0];

    if (XLEN < 64) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{out_q.imm[63:XLEN], out_q.target[63:XLEN], out_q.pc[63:XLEN]};
    end
endmodule
